hilo_muldiv_ctrl: RTL and testbench

//  Multi-cycle MULT/MULTU/DIV/DIVU sequencer feeding the HI/LO register in the execute stage.

---
 rtl/hilo_muldiv_ctrl_pkg.sv | 24 ++
 rtl/hilo_muldiv_ctrl_div_step.sv | 28 ++
 rtl/hilo_muldiv_ctrl.sv | 179 +++++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer: op encodings and FSM states.
package hilo_muldiv_ctrl_pkg;

  localparam logic [1:0] OpMult  = 2'b00;
  localparam logic [1:0] OpMultu = 2'b01;
  localparam logic [1:0] OpDiv   = 2'b10;
  localparam logic [1:0] OpDivu  = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StMul  = 2'b01,
    StDiv  = 2'b10,
    StDone = 2'b11
  } state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract, select.
module hilo_muldiv_ctrl_div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[DATA_W-1]};
    diff    = shifted - {1'b0, divisor_i};
    // A set MSB means the trial subtract borrowed, so the partial remainder is restored.
    if (diff[DATA_W]) begin
      rem_o = shifted[DATA_W-1:0];
      quo_o = {quo_i[DATA_W-2:0], 1'b0};
    end else begin
      rem_o = diff[DATA_W-1:0];
      quo_o = {quo_i[DATA_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer driving the HI/LO write port.
// Define MULDIV_FAST_DIV0_EN to finish a divide by zero in one cycle instead of iterating.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MULT_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] srca_i,
  input  logic [DATA_W-1:0] srcb_i,
  input  logic              cancel_i,
  output logic              busy_o,
  output logic              stall_o,
  output logic              hilo_we_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int unsigned CntMax = (DATA_W > MULT_LAT) ? DATA_W : MULT_LAT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] MulLast = CntW'(MULT_LAT - 1);
  localparam logic [CntW-1:0] DivLast = CntW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  // opa_q doubles as the quotient shift register while dividing.
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic              sa_in, sb_in;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [2*DATA_W-1:0] prod_mag, prod;
  logic [DATA_W-1:0] rem_nxt, quo_nxt;
  logic [DATA_W-1:0] quo_fix, rem_fix;

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic c);
    return c ? -v : v;
  endfunction

  hilo_muldiv_ctrl_div_step #(
    .DATA_W(DATA_W)
  ) u_div_step (
    .rem_i    (rem_q),
    .quo_i    (opa_q),
    .divisor_i(opb_q),
    .rem_o    (rem_nxt),
    .quo_o    (quo_nxt)
  );

  // Operands are kept as magnitudes; signs are applied once the result is formed.
  always_comb begin
    sa_in    = op_is_signed(op_i) & srca_i[DATA_W-1];
    sb_in    = op_is_signed(op_i) & srcb_i[DATA_W-1];
    a_mag    = cond_neg(srca_i, sa_in);
    b_mag    = cond_neg(srcb_i, sb_in);
    prod_mag = {{DATA_W{1'b0}}, opa_q} * {{DATA_W{1'b0}}, opb_q};
    prod     = (sa_q ^ sb_q) ? -prod_mag : prod_mag;
    quo_fix  = cond_neg(quo_nxt, sa_q ^ sb_q);
    rem_fix  = cond_neg(rem_nxt, sa_q);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    rem_d     = rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    stall_o   = 1'b0;
    hilo_we_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i && !cancel_i) begin
          stall_o = 1'b1;
          sa_d    = sa_in;
          sb_d    = sb_in;
          opa_d   = a_mag;
          opb_d   = b_mag;
          rem_d   = '0;
          cnt_d   = '0;
          if (!op_is_div(op_i)) begin
            state_d = StMul;
          end
`ifdef MULDIV_FAST_DIV0_EN
          else if (srcb_i == '0) begin
            state_d = StDone;
            lo_d    = cond_neg('1, sa_in ^ sb_in);
            hi_d    = cond_neg(a_mag, sa_in);
          end
`endif
          else begin
            state_d = StDiv;
          end
        end
      end

      StMul: begin
        stall_o = 1'b1;
        if (cancel_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == MulLast) begin
          state_d = StDone;
          cnt_d   = '0;
          hi_d    = prod[2*DATA_W-1:DATA_W];
          lo_d    = prod[DATA_W-1:0];
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StDiv: begin
        stall_o = 1'b1;
        opa_d   = quo_nxt;
        rem_d   = rem_nxt;
        if (cancel_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DivLast) begin
          state_d = StDone;
          cnt_d   = '0;
          hi_d    = rem_fix;
          lo_d    = quo_fix;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StDone: begin
        hilo_we_o = ~cancel_i;
        state_d   = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy_o = (state_q != StIdle);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: vector table plus hand-written cancel/reset/busy sequences.
module tb_hilo_muldiv_ctrl;
  import hilo_muldiv_ctrl_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned ML = 4;
  localparam int MulLat = ML + 1;
  localparam int DivLat = DW + 1;
`ifdef MULDIV_FAST_DIV0_EN
  localparam int Div0Lat = 1;
`else
  localparam int Div0Lat = DW + 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_i = 1'b0;
  logic [1:0]    op_i = 2'b00;
  logic [DW-1:0] srca_i = '0;
  logic [DW-1:0] srcb_i = '0;
  logic          cancel_i = 1'b0;
  logic          busy_o, stall_o, hilo_we_o;
  logic [DW-1:0] hi_o, lo_o;

  hilo_muldiv_ctrl #(
    .DATA_W  (DW),
    .MULT_LAT(ML)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .op_i     (op_i),
    .srca_i   (srca_i),
    .srcb_i   (srcb_i),
    .cancel_i (cancel_i),
    .busy_o   (busy_o),
    .stall_o  (stall_o),
    .hilo_we_o(hilo_we_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [1:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    int            lat;
  } vec_t;

  typedef struct {
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    int            lat;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[12];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one op at cycle 0, optionally keep start_i high for `hold` busy cycles with other
  // operands, and optionally raise start_i during DONE to show it is not accepted.
  task automatic run_op(input string nm, input logic [1:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] ehi,
                        input logic [DW-1:0] elo, input int lat, input int hold,
                        input bit done_start);
    exp_t e;
    bit   got;
    e.hi = ehi;
    e.lo = elo;
    e.lat = lat;
    start_i = 1'b1;
    op_i    = op;
    srca_i  = a;
    srcb_i  = b;
    sb_q.push_back(e);
    #1;
    chk({nm, " stall c0"}, 32'(stall_o), 32'd1);
    step();
    got = 1'b0;
    for (int c = 1; c <= 100 && !got; c++) begin
      if (c <= hold) begin
        start_i = 1'b1;
        op_i    = OpMult;
        srca_i  = 32'd2;
        srcb_i  = 32'd3;
      end else begin
        start_i = 1'b0;
      end
      #1;
      if (hilo_we_o) begin
        got = 1'b1;
        if (sb_q.size() == 0) begin
          chk({nm, " unexpected write"}, 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk({nm, " latency"}, 32'(c), 32'(e.lat));
          chk({nm, " hi"}, hi_o, e.hi);
          chk({nm, " lo"}, lo_o, e.lo);
          chk({nm, " stall done"}, 32'(stall_o), 32'd0);
        end
        if (done_start) begin
          start_i = 1'b1;
          op_i    = OpMult;
        end
      end else begin
        chk({nm, " stall busy"}, 32'(stall_o), 32'd1);
      end
      step();
    end
    start_i = 1'b0;
    chk({nm, " completed"}, 32'(got), 32'd1);
    #1;
    chk({nm, " idle after done"}, 32'(busy_o), 32'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"mult -3*5", OpMult, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, MulLat};
    vecs[1]  = '{"multu max*2", OpMultu, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, MulLat};
    vecs[2]  = '{"mult -1*-1", OpMult, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, MulLat};
    vecs[3]  = '{"mult min*min", OpMult, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MulLat};
    vecs[4]  = '{"multu 2^16*2^16", OpMultu, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, MulLat};
    vecs[5]  = '{"div -7/2", OpDiv, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DivLat};
    vecs[6]  = '{"divu 100/7", OpDivu, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, DivLat};
    vecs[7]  = '{"divu 100/0", OpDivu, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, Div0Lat};
    vecs[8]  = '{"div min/-1", OpDiv, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DivLat};
    vecs[9]  = '{"div 7/-2", OpDiv, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DivLat};
    vecs[10] = '{"divu max/1", OpDivu, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, DivLat};
    vecs[11] = '{"div -7/0", OpDiv, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'h00000001, Div0Lat};

    // Reset state
    step();
    step();
    chk("reset busy", 32'(busy_o), 32'd0);
    chk("reset stall", 32'(stall_o), 32'd0);
    chk("reset we", 32'(hilo_we_o), 32'd0);
    chk("reset hi", hi_o, 32'd0);
    chk("reset lo", lo_o, 32'd0);
    rst = 1'b1;
    step();

    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
             vecs[i].lat, 0, 1'b0);
    end

    // Start held high while busy must not re-latch operands; start during DONE not accepted.
    run_op("divu busy-start", OpDivu, 32'd100, 32'd7, 32'd2, 32'd14, DivLat, 5, 1'b0);
    run_op("multu done-start", OpMultu, 32'h00010000, 32'h00010000, 32'd1, 32'd0, MulLat, 0,
           1'b1);

    // Cancel at cycle 10 of a divide, then a fresh multiply.
    start_i = 1'b1;
    op_i    = OpDiv;
    srca_i  = 32'd100;
    srcb_i  = 32'd7;
    step();
    start_i = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 10) cancel_i = 1'b1;
      #1;
      chk("cancel no we", 32'(hilo_we_o), 32'd0);
      step();
    end
    cancel_i = 1'b0;
    #1;
    chk("cancel idle c11", 32'(busy_o), 32'd0);
    chk("cancel no we c11", 32'(hilo_we_o), 32'd0);
    step();
    run_op("mult 2*3 after cancel", OpMult, 32'd2, 32'd3, 32'd0, 32'd6, MulLat, 0, 1'b0);

    // Cancel during DONE suppresses the write strobe.
    start_i = 1'b1;
    op_i    = OpMult;
    srca_i  = 32'd4;
    srcb_i  = 32'd5;
    step();
    start_i = 1'b0;
    for (int c = 1; c <= MulLat; c++) begin
      if (c == MulLat) cancel_i = 1'b1;
      #1;
      chk("done-cancel no we", 32'(hilo_we_o), 32'd0);
      if (c == MulLat) chk("done-cancel busy", 32'(busy_o), 32'd1);
      step();
    end
    cancel_i = 1'b0;
    #1;
    chk("done-cancel idle", 32'(busy_o), 32'd0);
    step();

    // Cancel and start together in IDLE: cancel wins.
    start_i  = 1'b1;
    cancel_i = 1'b1;
    op_i     = OpDivu;
    #1;
    chk("start+cancel stall", 32'(stall_o), 32'd0);
    step();
    start_i  = 1'b0;
    cancel_i = 1'b0;
    #1;
    chk("start+cancel idle", 32'(busy_o), 32'd0);
    step();

    // Reset asserted at cycle 12 of a divide clears everything.
    start_i = 1'b1;
    op_i    = OpDiv;
    srca_i  = 32'hFFFFFFF9;
    srcb_i  = 32'd2;
    step();
    start_i = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 12) rst = 1'b0;
      #1;
      chk("pre-reset no we", 32'(hilo_we_o), 32'd0);
      step();
    end
    #1;
    chk("midop reset busy", 32'(busy_o), 32'd0);
    chk("midop reset stall", 32'(stall_o), 32'd0);
    chk("midop reset we", 32'(hilo_we_o), 32'd0);
    chk("midop reset hi", hi_o, 32'd0);
    chk("midop reset lo", lo_o, 32'd0);
    rst = 1'b1;
    step();
    for (int c = 0; c < 40; c++) begin
      #1;
      chk("post-reset no we", 32'(hilo_we_o), 32'd0);
      step();
    end

    chk("scoreboard empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
